// File: rtl/piu_pchinfo_stream.sv
//------------------------------------------------------------------------------
// piu_pchinfo_stream : scans the static patch ROM once per start and streams
// one {index, info, select, last} record per patch through a ready/valid slot.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef NUM_PCH
`define NUM_PCH 12
`endif
`ifndef PCHADDR_BW
`define PCHADDR_BW 4
`endif
`ifndef PCHSTAT_BW
`define PCHSTAT_BW 4
`endif

module piu_pchinfo_stream #(
  parameter int NUM_PCH    = `NUM_PCH,
  parameter int PCHADDR_BW = `PCHADDR_BW,
  parameter int PCHSTAT_BW = `PCHSTAT_BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_PCH-1:0]    sel_mask,
  output logic [PCHADDR_BW-1:0] pchidx,
  input  logic [PCHSTAT_BW-1:0] pchinfo_static,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCHADDR_BW-1:0] out_pchidx,
  output logic [PCHSTAT_BW-1:0] out_pchinfo,
  output logic                  out_sel,
  output logic                  out_last,
  output logic                  done,
  output logic [PCHADDR_BW:0]   sel_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [PCHADDR_BW-1:0] idx;
  logic [NUM_PCH-1:0]    mask;
  logic                  load;
  logic                  last_idx;

  // The slot refills in the same cycle it drains, so a held-high ready gives
  // one record per cycle with no bubble.
  assign load     = (state == SCAN) && (!out_valid || out_ready);
  assign last_idx = (idx == PCHADDR_BW'(NUM_PCH - 1));
  assign pchidx   = idx;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      mask        <= '0;
      out_valid   <= 1'b0;
      out_pchidx  <= '0;
      out_pchinfo <= '0;
      out_sel     <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      sel_count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mask      <= sel_mask;
            idx       <= '0;
            sel_count <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (load) begin
            out_pchidx  <= idx;
            out_pchinfo <= pchinfo_static;
            out_sel     <= mask[idx];
            out_last    <= last_idx;
            out_valid   <= 1'b1;
            sel_count   <= sel_count + (PCHADDR_BW + 1)'(mask[idx]);
            if (last_idx) begin
              state <= DRAIN;
            end else begin
              idx <= idx + PCHADDR_BW'(1);
            end
          end
        end
        DRAIN: begin
          // idx returns to 0 so the ROM address reads 0 while idle.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piu_pchinfo_stream.sv
// Randomized self-checking bench for piu_pchinfo_stream (12 patches, 3x4 grid).
`default_nettype none

module tb_piu_pchinfo_stream;

  localparam int N  = 12;
  localparam int AW = 4;
  localparam int SW = 4;

  localparam logic [1:0] ZT = 2'd1;
  localparam logic [1:0] ZB = 2'd2;
  localparam logic       I  = 1'b0;
  localparam logic       E  = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  sel_mask;
  logic [AW-1:0] pchidx;
  logic [SW-1:0] pchinfo_static;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pchidx;
  logic [SW-1:0] out_pchinfo;
  logic          out_sel;
  logic          out_last;
  logic          done;
  logic [AW:0]   sel_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SW-1:0] rec_info [N];

  always #5 clk = ~clk;

  piu_pchinfo_stream #(.NUM_PCH(N), .PCHADDR_BW(AW), .PCHSTAT_BW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_mask(sel_mask),
    .pchidx(pchidx), .pchinfo_static(pchinfo_static), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pchidx(out_pchidx),
    .out_pchinfo(out_pchinfo), .out_sel(out_sel), .out_last(out_last),
    .done(done), .sel_count(sel_count)
  );

  // Static patch ROM: row = i/4, col = i%4; info = {pchtype, z_bd, x_bd}.
  function automatic logic [SW-1:0] rom(input int i);
    int r, c;
    r = i / 4;
    c = i % 4;
    return {(r == 0) ? ZT : ZB, (r == 1) ? E : I, ((r == 0 && c == 0) || c == 3) ? E : I};
  endfunction

  always_comb begin
    pchinfo_static = '0;
    if (int'(pchidx) < N) pchinfo_static = rom(int'(pchidx));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: stall 3 cycles on index 5.
  task automatic run_scan(input logic [N-1:0] m, input int mode, input bit restart,
                          input int abort_idx);
    int  c, next, stalls, n5, stall5, exp_pidx;
    bit  last_acc, fin, exp_valid, ready;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pchidx", pchidx, 0);
    start = 1'b1; sel_mask = m; out_ready = 1'b1;
    c = 0; next = 0; stalls = 0; n5 = 0; stall5 = 0; last_acc = 0; fin = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      c++;
      start    = restart && (c == 4);
      sel_mask = N'($urandom);
      exp_valid = (c >= 2) && (next < N);
      chk("done", done, last_acc);
      chk("valid", out_valid, exp_valid);
      chk("busy", busy, !last_acc);
      exp_pidx = next + int'(exp_valid);
      if (exp_pidx > N - 1) exp_pidx = N - 1;
      if (last_acc) exp_pidx = 0;
      chk("pchidx", pchidx, exp_pidx);
      if (exp_valid)
        chk("record", {out_pchidx, out_pchinfo, out_sel, out_last},
            {next[AW-1:0], rom(next), m[next], next == N - 1});
      if (last_acc) begin
        chk("sel_count", sel_count, $countones(m));
        chk("latency", c, N + 2 + stalls);
        fin = 1;
        break;
      end
      if (abort_idx >= 0 && exp_valid && next == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort", {out_valid, busy, done, out_pchidx, out_pchinfo, out_sel, out_last,
                      sel_count, pchidx}, 0);
        return;
      end
      ready = (mode == 0) ? 1'b1 :
              (mode == 1) ? 1'($urandom_range(0, 1)) :
              !(exp_valid && next == 5 && stall5 < 3);
      if (mode == 2 && exp_valid && next == 5 && !ready) stall5++;
      if (exp_valid && next == 5) n5++;
      out_ready = ready;
      if (exp_valid && !ready) stalls++;
      if (exp_valid && ready) begin
        rec_info[next] = out_pchinfo;
        next++;
        if (next == N) last_acc = 1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (mode == 2) chk("idx5_hold", n5, 4);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("sel_hold", sel_count, $countones(m));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel_mask = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {out_valid, busy, done, out_pchidx, out_pchinfo, out_sel, out_last,
                  sel_count, pchidx}, 0);
    rst = 1'b0;

    run_scan(12'hFFF, 0, 0, -1);
    run_scan(12'h005, 0, 0, -1);
    chk("rom_idx0", rec_info[0], {ZT, I, E});
    chk("rom_idx4", rec_info[4], {ZB, E, I});
    run_scan(N'($urandom), 2, 0, -1);
    run_scan(N'($urandom), 0, 1, -1);
    run_scan(N'($urandom), 0, 0, 7);
    run_scan(12'hA5C, 0, 0, -1);

    // start coincident with rst must be dropped
    @(negedge clk);
    rst = 1'b1; start = 1'b1; sel_mask = 12'hFFF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_valid", out_valid, 0);

    for (int t = 0; t < 6; t++) run_scan(N'($urandom), 1, t[0], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
